lcd_field_writer: RTL and testbench
===================================

Name: lcd_field_writer

Overview:
- Parametrised successor to the single-line status writer. Renders NUM_VALS labelled decimal fields onto the 16x2 character LCD through the Avalon-MM LCD_Controller slave.
- Performs the init sequence once after reset, then redraws fields only when an input value changes or a refresh is forced.
- Converts binary to BCD internally with sequential double-dabble, so no combinational divide is needed.
- Sits between the tracking/command logic and the LCD_Controller.

Parameters:
- NUM_VALS, 2, number of displayed fields; legal range 1..4.
- VAL_WIDTH, 6, bit width of each field value; legal range 1..20.
- VAL_DIGITS, 2, decimal digits per field; legal range 1..5.
- LABELS, 16'h4443, packed ASCII label character per field; field k label is LABELS[8k+:8]. The default gives field0 'C' and field1 'D'.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- values  in  NUM_VALS*VAL_WIDTH  field k is values[k*VAL_WIDTH+:VAL_WIDTH].
- force_refresh  in  1  single-cycle pulse that requests a full redraw.
- busy  out  1  high from reset until the end of the init/refresh in progress.
- refresh_done  out  1  one-cycle pulse after the last write of a refresh.
- address  out  1  0 = instruction register, 1 = data register.
- chipselect  out  1  Avalon chip select.
- byteenable  out  1  tied 1.
- read  out  1  tied 0.
- write  out  1  Avalon write strobe.
- waitrequest  in  1  slave stall.
- readdata  in  8  unused.
- response  in  2  unused.
- writedata  out  8  instruction or ASCII character.

Behaviour:
- Clock and reset:
  - One clock domain: clk. Reset is synchronous and active-high.
  - While reset is sampled high: write=0, chipselect=0, address=0, writedata=0, busy=1, refresh_done=0, and the FSM enters INIT_CLR.
  - A reset during a transfer abandons that transfer. The controller sees write drop on the next edge.
- Avalon transfer rules:
  - Each transfer drives write=1 and chipselect=1 with address and writedata held stable.
  - A transfer completes on the first rising edge where write=1 and waitrequest=0.
  - After completion, write=0 and chipselect=0 for exactly one cycle (GAP) before the next transfer.
  - Outputs must not change while waitrequest=1.
- FSM states:
  - INIT_CLR: write 0x01, address 0.
  - INIT_DISP: write 0x0C, address 0.
  - IDLE
  - SNAP: latch all values into snap_reg; clear the pending flag.
  - CONV: double-dabble of field k, one shift per cycle, VAL_WIDTH cycles into 4*VAL_DIGITS BCD bits.
  - SET_ADDR: write 0x80 | (0x40 if k>=2) | ((k%2)*8), address 0.
  - WR_LABEL: write LABELS[8k+:8], address 1.
  - WR_COLON: write 0x3A, address 1.
  - WR_DIGITS: write VAL_DIGITS characters, most significant first, address 1.
  - NEXT: k+1; go to CONV, or to DONE after field NUM_VALS-1.
  - DONE: shown_reg <= snap_reg; pulse refresh_done; return to IDLE.
- Sequencing:
  - After INIT_DISP the FSM always performs one full refresh.
  - Each refresh performs NUM_VALS*(3+VAL_DIGITS) transfers (+NUM_VALS with SIGNED_VAL_EN).
- Digit encoding:
  - Each digit is 0x30 + BCD nibble. Leading zeros are shown as '0'.
  - If value > 10^VAL_DIGITS-1, every digit of that field is '#' (0x23).
- Refresh triggering:
  - IDLE goes to SNAP when values != shown_reg or the pending flag is set. Otherwise IDLE stays put, issues no writes, and holds busy=0.
  - force_refresh sets the pending flag in any state. The flag is cleared only in SNAP, so a request during a refresh produces exactly one extra refresh.
- Values changing mid-refresh: the values written are those latched at SNAP. A later difference against shown_reg triggers the next refresh automatically.
- busy is 0 only in IDLE.

Optional Feature:
- Macro: LCD_FIELD_SIGNED_VAL_EN.
- With the macro defined:
  - Values are treated as two's complement.
  - A sign character is written between the colon and the digits: '-' (0x2D) when negative, ' ' (0x20) otherwise.
  - The magnitude is converted. The overflow test applies to the magnitude, so the most negative value is handled without wrap.
  - Legal VAL_DIGITS becomes 1..4 to fit the 8-column slot.
- Without the macro: values are unsigned and no sign character is written.

Test Plan:
- Reset then release, waitrequest=0, values C=3, D=25:
  - Transfers in order: (0,0x01) (0,0x0C) (0,0x80) (1,'C') (1,':') (1,'0') (1,'3') (0,0x88) (1,'D') (1,':') (1,'2') (1,'5').
  - refresh_done pulses once; busy=0 afterwards; one idle cycle between transfers.
- Hold waitrequest=1 for 5 cycles during the (1,'2') transfer: address, writedata and write are stable for all 5 cycles; the transfer completes once, with no duplicate character.
- Values D=63 with VAL_DIGITS=2 and VAL_WIDTH=6: the field shows '6','3'. With VAL_DIGITS=1 it shows '#'.
- Values unchanged for 200 cycles: zero transfers. Then force_refresh pulse: exactly one full refresh (10 transfers after init).
- Change C from 3 to 4 during the field1 digit writes: the current refresh still writes '3', and a second refresh writes '4' immediately after. Assert reset mid-transfer: write=0 next cycle, and the sequence restarts with (0,0x01).
- With LCD_FIELD_SIGNED_VAL_EN, VAL_WIDTH=6, C=-7: field0 writes 'C',':','-','0','7'. With C=-32 and VAL_DIGITS=2 it writes 'C',':','-','3','2'.

Source files
------------

// File: rtl/lcd_field_writer.sv
// Renders NUM_VALS labelled decimal fields on a 16x2 LCD through the Avalon-MM LCD_Controller slave.
// Optional signed display (sign character, magnitude conversion) is enabled by defining LCD_FIELD_SIGNED_VAL_EN.
module lcd_field_writer #(
    parameter int                    NUM_VALS   = 2,
    parameter int                    VAL_WIDTH  = 6,
    parameter int                    VAL_DIGITS = 2,
    parameter logic [8*NUM_VALS-1:0] LABELS     = 16'h4443
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_VALS*VAL_WIDTH-1:0] values,
    input  logic                          force_refresh,
    output logic                          busy,
    output logic                          refresh_done,
    output logic                          address,
    output logic                          chipselect,
    output logic                          byteenable,
    output logic                          read,
    output logic                          write,
    input  logic                          waitrequest,
    input  logic [7:0]                    readdata,
    input  logic [1:0]                    response,
    output logic [7:0]                    writedata
);

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam int FW      = NUM_VALS * VAL_WIDTH;
    localparam int BCD_W   = 4 * VAL_DIGITS;
    localparam int MAX_MAG = pow10(VAL_DIGITS) - 1;

    typedef enum logic [3:0] {
        INIT_CLR, INIT_DISP, IDLE, SNAP, CONV, SET_ADDR,
        WR_LABEL, WR_COLON, WR_SIGN, WR_DIGITS, NEXT, DONE
    } state_t;

    // Add-3 correction applied to every BCD nibble before each double-dabble shift.
    function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < VAL_DIGITS; i++) begin
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Out-of-range fields saturate to '#' in every digit position.
    function automatic logic [7:0] digit_char(input logic [3:0] nib, input logic sat);
        return sat ? 8'h23 : (8'h30 + {4'h0, nib});
    endfunction

    function automatic logic [VAL_WIDTH-1:0] magnitude(input logic [VAL_WIDTH-1:0] v);
`ifdef LCD_FIELD_SIGNED_VAL_EN
        logic signed [VAL_WIDTH-1:0] s;
        s = $signed(v);
        return v[VAL_WIDTH-1] ? $unsigned(-s) : v;
`else
        return v;
`endif
    endfunction

    state_t                state, next_state;
    logic                  gap, pend, xfer_done;
    logic                  wr_c, addr_c;
    logic [7:0]            data_c;
    logic [1:0]            k;
    logic [2:0]            dig;
    logic [4:0]            bit_cnt;
    logic [FW-1:0]         snap_reg, shown_reg;
    logic [VAL_WIDTH-1:0]  field_k, mag_k, shreg;
    logic [BCD_W-1:0]      bcd;
    logic                  ovf;
    logic [3:0]            nib;
    logic                  unused_inputs;
`ifdef LCD_FIELD_SIGNED_VAL_EN
    logic                  neg;
`endif

    assign field_k = snap_reg[int'(k)*VAL_WIDTH +: VAL_WIDTH];
    assign mag_k   = magnitude(field_k);
    assign nib     = bcd[4*(VAL_DIGITS-1-int'(dig)) +: 4];

    assign unused_inputs = ^{readdata, response};

    // Bus outputs are decoded from state; gap forces one idle cycle after each completed transfer.
    assign xfer_done    = wr_c && !waitrequest;
    assign write        = wr_c;
    assign chipselect   = wr_c;
    assign address      = wr_c ? addr_c : 1'b0;
    assign writedata    = wr_c ? data_c : 8'h00;
    assign byteenable   = 1'b1;
    assign read         = 1'b0;
    assign busy         = (state != IDLE);
    assign refresh_done = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) state <= INIT_CLR;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        wr_c       = 1'b0;
        addr_c     = 1'b0;
        data_c     = 8'h00;
        case (state)
            INIT_CLR: begin
                wr_c   = !gap;
                data_c = 8'h01;
                if (xfer_done) next_state = INIT_DISP;
            end
            INIT_DISP: begin
                wr_c   = !gap;
                data_c = 8'h0C;
                if (xfer_done) next_state = SNAP;
            end
            IDLE: begin
                if (values != shown_reg || pend) next_state = SNAP;
            end
            SNAP: next_state = CONV;
            CONV: begin
                if (bit_cnt == 5'(VAL_WIDTH)) next_state = SET_ADDR;
            end
            SET_ADDR: begin
                wr_c   = !gap;
                data_c = 8'h80 | ((k >= 2'd2) ? 8'h40 : 8'h00) | (k[0] ? 8'h08 : 8'h00);
                if (xfer_done) next_state = WR_LABEL;
            end
            WR_LABEL: begin
                wr_c   = !gap;
                addr_c = 1'b1;
                data_c = LABELS[8*int'(k) +: 8];
                if (xfer_done) next_state = WR_COLON;
            end
            WR_COLON: begin
                wr_c   = !gap;
                addr_c = 1'b1;
                data_c = 8'h3A;
`ifdef LCD_FIELD_SIGNED_VAL_EN
                if (xfer_done) next_state = WR_SIGN;
`else
                if (xfer_done) next_state = WR_DIGITS;
`endif
            end
`ifdef LCD_FIELD_SIGNED_VAL_EN
            WR_SIGN: begin
                wr_c   = !gap;
                addr_c = 1'b1;
                data_c = neg ? 8'h2D : 8'h20;
                if (xfer_done) next_state = WR_DIGITS;
            end
`endif
            WR_DIGITS: begin
                wr_c   = !gap;
                addr_c = 1'b1;
                data_c = digit_char(nib, ovf);
                if (xfer_done && dig == 3'(VAL_DIGITS-1)) next_state = NEXT;
            end
            NEXT: next_state = (k == 2'(NUM_VALS-1)) ? DONE : CONV;
            DONE: next_state = IDLE;
            default: next_state = INIT_CLR;
        endcase
    end

    // Control state; the pending request wins over its clear so a request in SNAP is not lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            gap     <= 1'b1;
            pend    <= 1'b0;
            k       <= 2'd0;
            dig     <= 3'd0;
            bit_cnt <= 5'd0;
        end else begin
            gap <= xfer_done;
            if (force_refresh)       pend <= 1'b1;
            else if (state == SNAP)  pend <= 1'b0;
            case (state)
                SNAP: begin
                    k       <= 2'd0;
                    bit_cnt <= 5'd0;
                end
                CONV: bit_cnt <= (bit_cnt == 5'(VAL_WIDTH)) ? 5'd0 : bit_cnt + 5'd1;
                WR_DIGITS: begin
                    if (xfer_done) dig <= (dig == 3'(VAL_DIGITS-1)) ? 3'd0 : dig + 3'd1;
                end
                NEXT: k <= k + 2'd1;
                default: ;
            endcase
        end
    end

    // Datapath: snapshot, double-dabble conversion (load cycle then VAL_WIDTH shifts), shown copy.
    always_ff @(posedge clk) begin
        case (state)
            SNAP: snap_reg <= values;
            CONV: begin
                if (bit_cnt == 5'd0) begin
                    shreg <= mag_k;
                    bcd   <= '0;
                    ovf   <= {{(32-VAL_WIDTH){1'b0}}, mag_k} > MAX_MAG[31:0];
`ifdef LCD_FIELD_SIGNED_VAL_EN
                    neg   <= field_k[VAL_WIDTH-1];
`endif
                end else begin
                    {bcd, shreg} <= {dd_adjust(bcd), shreg} << 1;
                end
            end
            DONE: shown_reg <= snap_reg;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lcd_field_writer.sv
// Self-checking bench for lcd_field_writer: directed LCD write sequences plus random values against a reference model.
module tb_lcd_field_writer;

    typedef logic [8:0] xf_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        force_refresh = 1'b0;
    logic        waitrequest = 1'b0;
    logic        wait1 = 1'b0;
    logic [11:0] values = {6'd25, 6'd3};
    logic [7:0]  readdata = 8'h00;
    logic [1:0]  response = 2'b00;

    logic busy, refresh_done, address, chipselect, byteenable, read, write;
    logic [7:0] writedata;
    logic busy_1, refresh_done_1, address_1, chipselect_1, byteenable_1, read_1, write_1;
    logic [7:0] writedata_1;

    int checks = 0, errors = 0;
    int done_cnt = 0, min_gap = 1000, idle_run = 0, cs_bad = 0;
    bit seen = 1'b0;
    xf_t q[$], q1[$], expq[$];

    lcd_field_writer #(.NUM_VALS(2), .VAL_WIDTH(6), .VAL_DIGITS(2), .LABELS(16'h4443)) u_dut (
        .clk(clk), .reset(reset), .values(values), .force_refresh(force_refresh),
        .busy(busy), .refresh_done(refresh_done), .address(address), .chipselect(chipselect),
        .byteenable(byteenable), .read(read), .write(write), .waitrequest(waitrequest),
        .readdata(readdata), .response(response), .writedata(writedata)
    );

    lcd_field_writer #(.NUM_VALS(2), .VAL_WIDTH(6), .VAL_DIGITS(1), .LABELS(16'h4443)) u_dut1 (
        .clk(clk), .reset(reset), .values(values), .force_refresh(force_refresh),
        .busy(busy_1), .refresh_done(refresh_done_1), .address(address_1), .chipselect(chipselect_1),
        .byteenable(byteenable_1), .read(read_1), .write(write_1), .waitrequest(wait1),
        .readdata(readdata), .response(response), .writedata(writedata_1)
    );

    always #5 clk = ~clk;

    // Transfers are logged half a cycle before the edge that completes them.
    always @(negedge clk) begin
        if (reset) begin
            seen = 1'b0;
            idle_run = 0;
        end else begin
            if (chipselect !== write) cs_bad++;
            if (write && !waitrequest) begin
                q.push_back({address, writedata});
                if (seen && idle_run < min_gap) min_gap = idle_run;
                seen = 1'b1;
                idle_run = 0;
            end else if (!write) begin
                idle_run++;
            end
            if (refresh_done) done_cnt++;
            if (write_1) q1.push_back({address_1, writedata_1});
        end
    end

    function automatic void model_refresh(input logic [11:0] v, input int digits);
        for (int k = 0; k < 2; k++) begin
            logic [5:0] f;
            int mag, lim, p;
            f = v[k*6 +: 6];
            expq.push_back({1'b0, 8'(8'h80 + ((k >= 2) ? 8'h40 : 8'h00) + (k % 2) * 8)});
            expq.push_back({1'b1, (k == 0) ? 8'h43 : 8'h44});
            expq.push_back({1'b1, 8'h3A});
`ifdef LCD_FIELD_SIGNED_VAL_EN
            if (f[5]) begin
                mag = 64 - int'(f);
                expq.push_back({1'b1, 8'h2D});
            end else begin
                mag = int'(f);
                expq.push_back({1'b1, 8'h20});
            end
`else
            mag = int'(f);
`endif
            lim = 1;
            for (int i = 0; i < digits; i++) lim = lim * 10;
            lim = lim - 1;
            for (int d = digits - 1; d >= 0; d--) begin
                p = 1;
                for (int i = 0; i < d; i++) p = p * 10;
                if (mag > lim) expq.push_back({1'b1, 8'h23});
                else           expq.push_back({1'b1, 8'(48 + (mag / p) % 10)});
            end
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp_q(input string tag);
        check({tag, "_len"}, q.size(), expq.size());
        for (int i = 0; i < expq.size() && i < q.size(); i++) check(tag, q[i], expq[i]);
    endtask

    task automatic cmp_last1(input string tag);
        int off;
        off = q1.size() - expq.size();
        check({tag, "_len"}, (off >= 0), 1);
        if (off >= 0)
            for (int i = 0; i < expq.size(); i++) check(tag, q1[off+i], expq[i]);
    endtask

    task automatic pulse_force();
        force_refresh = 1'b1;
        step();
        force_refresh = 1'b0;
    endtask

    // Waits for refresh_done count to reach target; optional random stalls with output-hold checking.
    task automatic wait_done(input int target, input string tag, input bit rnd);
        int n;
        bit pw, pwt;
        logic pa;
        logic [7:0] pd;
        n = 0; pw = 1'b0; pwt = 1'b0; pa = 1'b0; pd = 8'h00;
        while (done_cnt < target && n < 4000) begin
            step();
            n++;
            if (pw && pwt) check("stall_hold", {write, address, writedata}, {1'b1, pa, pd});
            if (rnd) waitrequest = ($urandom_range(0, 2) == 0);
            pw = write; pwt = waitrequest; pa = address; pd = writedata;
        end
        waitrequest = 1'b0;
        check({tag, "_timeout"}, (done_cnt >= target), 1);
    endtask

    task automatic find_write(input logic a, input logic [7:0] d, input string tag);
        int n;
        n = 0;
        while (!(write && address == a && writedata == d) && n < 500) begin
            step();
            n++;
        end
        check({tag, "_found"}, (n < 500), 1);
    endtask

    initial begin
        int base, n, bcnt;
        logic [11:0] nv;

        // Reset state
        repeat (3) step();
        check("rst_write", write, 0);
        check("rst_cs", chipselect, 0);
        check("rst_addr", address, 0);
        check("rst_data", writedata, 0);
        check("rst_busy", busy, 1);
        check("rst_done", refresh_done, 0);
        reset = 1'b0;

        // Init sequence and first refresh
        wait_done(1, "init", 1'b0);
        step();
        expq.delete();
        expq.push_back({1'b0, 8'h01});
        expq.push_back({1'b0, 8'h0C});
        model_refresh(values, 2);
        cmp_q("init_seq");
        check("init_done_once", done_cnt, 1);
        check("init_busy_low", busy, 0);
        check("init_min_gap", min_gap, 1);
        check("tied_outputs", {byteenable, read}, 2'b10);
        check("cs_tracks_write", cs_bad, 0);

        // Five-cycle stall during the (1,'2') transfer
        q.delete();
        base = done_cnt;
        pulse_force();
        find_write(1'b1, 8'h32, "stall");
        waitrequest = 1'b1;
        repeat (5) begin
            step();
            check("stall5", {write, chipselect, address, writedata}, {1'b1, 1'b1, 1'b1, 8'h32});
        end
        waitrequest = 1'b0;
        wait_done(base + 1, "stall_ref", 1'b0);
        expq.delete();
        model_refresh(values, 2);
        cmp_q("stall_seq");

        // Unchanged values: quiet for 200 cycles
        q.delete();
        bcnt = 0;
        repeat (200) begin
            step();
            if (busy) bcnt++;
        end
        check("idle_no_xfer", q.size(), 0);
        check("idle_busy_low", bcnt, 0);

        // Forced refresh: exactly one
        base = done_cnt;
        pulse_force();
        wait_done(base + 1, "force", 1'b0);
        repeat (50) step();
        check("force_len10", q.size(), 10);
        check("force_one", done_cnt, base + 1);
        expq.delete();
        model_refresh(values, 2);
        cmp_q("force_seq");

        // Value change mid-refresh: old snapshot completes, then automatic second refresh
        q.delete();
        base = done_cnt;
        pulse_force();
        find_write(1'b1, 8'h32, "midchg");
        values[5:0] = 6'd4;
        wait_done(base + 2, "midchg", 1'b0);
        expq.delete();
        model_refresh({6'd25, 6'd3}, 2);
        model_refresh(values, 2);
        cmp_q("midchg_seq");

        // D=63: two digits on main DUT, saturation check on the one-digit instance
        q.delete();
        base = done_cnt;
        values[11:6] = 6'd63;
        wait_done(base + 1, "d63", 1'b0);
        expq.delete();
        model_refresh(values, 2);
        cmp_q("d63_seq");
        n = 0;
        while (busy_1 && n < 200) begin
            step();
            n++;
        end
        expq.delete();
        model_refresh(values, 1);
        cmp_last1("d63_dig1");

        // Boundary and random values with random stalls
        for (int it = 0; it < 8; it++) begin
            case (it)
                0: nv = 12'h000;
                1: nv = 12'hFFF;
                2: nv = {6'd9, 6'd10};
                3: nv = {6'd32, 6'd31};
                default: nv = 12'($urandom());
            endcase
            if (nv == values) nv = nv ^ 12'h001;
            q.delete();
            base = done_cnt;
            values = nv;
            wait_done(base + 1, "rnd", 1'b1);
            expq.delete();
            model_refresh(values, 2);
            cmp_q("rnd_seq");
        end

`ifdef LCD_FIELD_SIGNED_VAL_EN
        // Signed fields: -7 and most-negative -32
        q.delete();
        base = done_cnt;
        values[5:0] = 6'd57;
        wait_done(base + 1, "neg7", 1'b0);
        expq.delete();
        model_refresh(values, 2);
        cmp_q("neg7_seq");
        q.delete();
        base = done_cnt;
        values[5:0] = 6'd32;
        wait_done(base + 1, "neg32", 1'b0);
        expq.delete();
        model_refresh(values, 2);
        cmp_q("neg32_seq");
`endif

        // Reset during a stalled transfer
        waitrequest = 1'b1;
        pulse_force();
        n = 0;
        while (!write && n < 500) begin
            step();
            n++;
        end
        check("rst_mid_found", (n < 500), 1);
        reset = 1'b1;
        step();
        check("rst_mid_drop", {write, chipselect}, 2'b00);
        check("rst_mid_busy", busy, 1);
        reset = 1'b0;
        waitrequest = 1'b0;
        q.delete();
        base = done_cnt;
        wait_done(base + 1, "rst_re", 1'b0);
        expq.delete();
        expq.push_back({1'b0, 8'h01});
        expq.push_back({1'b0, 8'h0C});
        model_refresh(values, 2);
        cmp_q("rst_seq");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
